// File: rtl/tlu_clk_en_pkg.sv
// tlu_clk_en_pkg: shared FSM encoding, relock saturation limit and divider helper
// for the lock-supervised clock-enable generator.
package tlu_clk_en_pkg;
    typedef enum logic [1:0] {
        S_LOCK_WAIT = 2'd0,
        S_ALIGN     = 2'd1,
        S_RUN       = 2'd2
    } state_t;
    localparam logic [7:0] RELOCK_CNT_MAX = 8'd255;
    function automatic logic [31:0] half_ceil(input logic [31:0] n);
        return (n + 32'd1) >> 1;
    endfunction
endpackage

// File: rtl/tlu_clk_en_gen_if.sv
// tlu_clk_en_gen_if: BUS_CLK-domain control and divided outputs of the
// clock-enable generator.
interface tlu_clk_en_gen_if #(
    parameter int CHANNELS  = 4,
    parameter int DIV_WIDTH = 8
);
    logic [CHANNELS*DIV_WIDTH-1:0] DIV;
    logic [CHANNELS*DIV_WIDTH-1:0] PHASE;
    logic [CHANNELS-1:0]           CH_EN;
    logic                          SYNC;
    logic [CHANNELS-1:0]           CE_OUT;
    logic [CHANNELS-1:0]           CLK_OUT;
    logic                          READY;
    logic [7:0]                    RELOCK_CNT;
    modport master (
        output DIV, PHASE, CH_EN, SYNC,
        input  CE_OUT, CLK_OUT, READY, RELOCK_CNT
    );
    modport slave (
        input  DIV, PHASE, CH_EN, SYNC,
        output CE_OUT, CLK_OUT, READY, RELOCK_CNT
    );
endinterface

// File: rtl/tlu_clk_en_chan.sv
// tlu_clk_en_chan: one divider channel; shadows ratio/enable at ALIGN and decodes
// the enable strobe and divided level from its wrap counter.
module tlu_clk_en_chan
    import tlu_clk_en_pkg::*;
#(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_align,
    input  logic                 i_run,
    input  logic                 i_en,
    input  logic [DIV_WIDTH-1:0] i_div,
    input  logic [DIV_WIDTH-1:0] i_phase,
    output logic                 o_ce,
    output logic                 o_clk
);
    logic [DIV_WIDTH-1:0] r_div;
    logic [DIV_WIDTH-1:0] r_cnt;
    logic                 r_en;
    logic                 w_act;
    logic                 w_last;
    logic [DIV_WIDTH:0]   w_half;
    assign w_act  = i_run & r_en & (r_div != '0);
    assign w_last = (r_cnt == r_div - DIV_WIDTH'(1));
    assign w_half = (DIV_WIDTH+1)'(half_ceil(32'(r_div)));
    assign o_ce   = w_act & w_last;
    assign o_clk  = w_act & ({1'b0, r_cnt} < w_half);
    // An out-of-range phase restarts the channel at count 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
            r_en  <= 1'b0;
            r_cnt <= '0;
        end else if (i_align) begin
            r_div <= i_div;
            r_en  <= i_en;
            r_cnt <= (i_phase < i_div) ? i_phase : '0;
        end else if (w_act) begin
            r_cnt <= w_last ? '0 : r_cnt + DIV_WIDTH'(1);
        end
    end
endmodule

// File: rtl/tlu_clk_en_gen.sv
// tlu_clk_en_gen: lock-supervised clock-enable generator; waits for a stable DCM
// lock, aligns all divider channels, and re-sequences after every lock loss.
module tlu_clk_en_gen
    import tlu_clk_en_pkg::*;
#(
    parameter int CHANNELS       = 4,
    parameter int DIV_WIDTH      = 8,
    parameter int LOCK_WAIT      = 1024,
    parameter int LOCK_CNT_WIDTH = 11
) (
    input  logic              BUS_CLK,
    input  logic              RST_N,
    input  logic              LOCKED_IN,
    tlu_clk_en_gen_if.slave   bus
);
    localparam logic [LOCK_CNT_WIDTH-1:0] LOCK_LAST = LOCK_CNT_WIDTH'(LOCK_WAIT - 1);
    logic                      r_sync1;
    logic                      r_lock_s;
    logic [LOCK_CNT_WIDTH-1:0] r_lock_cnt;
    logic [LOCK_CNT_WIDTH-1:0] w_lock_cnt_nxt;
    logic [7:0]                r_relock;
    logic [7:0]                w_relock_nxt;
    state_t                    r_state;
    state_t                    w_state_nxt;
    logic                      w_align;
    logic                      w_run;
    logic [CHANNELS-1:0]       w_ce;
    logic [CHANNELS-1:0]       w_clk;
    always_ff @(posedge BUS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sync1    <= 1'b0;
            r_lock_s   <= 1'b0;
            r_lock_cnt <= '0;
            r_relock   <= '0;
            r_state    <= S_LOCK_WAIT;
        end else begin
            r_sync1    <= LOCKED_IN;
            r_lock_s   <= r_sync1;
            r_lock_cnt <= w_lock_cnt_nxt;
            r_relock   <= w_relock_nxt;
            r_state    <= w_state_nxt;
        end
    end
    // Lock loss outranks SYNC and applies equally in ALIGN and RUN.
    always_comb begin
        w_state_nxt    = r_state;
        w_lock_cnt_nxt = r_lock_cnt;
        w_relock_nxt   = r_relock;
        if (r_state == S_LOCK_WAIT) begin
            if (!r_lock_s) w_lock_cnt_nxt = '0;
            else if (r_lock_cnt == LOCK_LAST) w_state_nxt = S_ALIGN;
            else w_lock_cnt_nxt = r_lock_cnt + LOCK_CNT_WIDTH'(1);
        end else if (!r_lock_s) begin
            w_state_nxt    = S_LOCK_WAIT;
            w_lock_cnt_nxt = '0;
            w_relock_nxt   = (r_relock == RELOCK_CNT_MAX) ? r_relock : r_relock + 8'd1;
        end else if (r_state == S_ALIGN) begin
            w_state_nxt = S_RUN;
        end else if (bus.SYNC) begin
            w_state_nxt = S_ALIGN;
        end
    end
    assign w_align        = (r_state == S_ALIGN);
    assign w_run          = (r_state == S_RUN);
    assign bus.READY      = w_run;
    assign bus.RELOCK_CNT = r_relock;
    assign bus.CE_OUT     = w_ce;
    assign bus.CLK_OUT    = w_clk;
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        tlu_clk_en_chan #(.DIV_WIDTH(DIV_WIDTH)) u_chan (
            .clk     (BUS_CLK),
            .rst_n   (RST_N),
            .i_align (w_align),
            .i_run   (w_run),
            .i_en    (bus.CH_EN[i]),
            .i_div   (bus.DIV[i*DIV_WIDTH +: DIV_WIDTH]),
            .i_phase (bus.PHASE[i*DIV_WIDTH +: DIV_WIDTH]),
            .o_ce    (w_ce[i]),
            .o_clk   (w_clk[i])
        );
    end
endmodule
